cgra_output_arbiter: RTL and testbench

Sequences the CGRA output nodes onto the single DMA write path. It shares one write-request channel between NUM_OUTPUTS output streams, generates per-stream incrementing addresses from CSR base/size values, and tracks outstanding write responses. It raises done once every stream has been fully written and acknowledged, and exposes a stall flag to the performance counters. It sits between the CGRA `data_out*` ports and the DMA write engine and is started by the control unit's execute-output pulse.

---
 rtl/cgra_output_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cgra_output_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_output_arbiter.sv
// rtl/cgra_output_arbiter.sv - shares one DMA write-request channel between CGRA output streams
module cgra_output_arbiter #(
    parameter int NUM_OUTPUTS     = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SIZE_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              hold_i,
    input  logic [NUM_OUTPUTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_OUTPUTS*SIZE_WIDTH-1:0] size_i,
    input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_i,
    input  logic [NUM_OUTPUTS-1:0]            valid_i,
    output logic [NUM_OUTPUTS-1:0]            ready_o,
    output logic                              wr_valid_o,
    input  logic                              wr_ready_i,
    output logic [ADDR_WIDTH-1:0]             wr_addr_o,
    output logic [DATA_WIDTH-1:0]             wr_data_o,
    input  logic                              wr_rsp_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              stall_o
);
    localparam int IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [OUT_W-1:0]      OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cur_addr [NUM_OUTPUTS];
    logic [SIZE_WIDTH-1:0]  rem      [NUM_OUTPUTS];
    logic [IDX_W-1:0]       rr_ptr;
    logic [OUT_W-1:0]       outstanding;
    logic                   lock_valid;
    logic [IDX_W-1:0]       lock_idx;

    logic [NUM_OUTPUTS-1:0] eligible;
    logic                   any_eligible;
    logic                   all_zero;
    logic                   start_zero;
    logic                   lock_active;
    logic                   accept;
    logic                   rsp_eff;
    logic [OUT_W-1:0]       outstanding_next;
    logic                   slot_free;
    logic                   grant_hit;
    logic                   grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0]  grant_data;
    logic [ADDR_WIDTH-1:0]  grant_addr;
    int                     scan_j;

    always_comb begin
        eligible   = '0;
        all_zero   = 1'b1;
        start_zero = 1'b1;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            eligible[k] = valid_i[k] && (rem[k] != '0);
            if (rem[k] != '0) all_zero = 1'b0;
            if (size_i[k*SIZE_WIDTH +: SIZE_WIDTH] != '0) start_zero = 1'b0;
        end
    end

    assign any_eligible = |eligible;
    // The lock releases itself once the locked stream has no words left.
    assign lock_active  = lock_valid && (rem[lock_idx] != '0);

    assign accept  = wr_valid_o && wr_ready_i;
    assign rsp_eff = wr_rsp_i && (outstanding != '0);
    assign outstanding_next = outstanding + OUT_W'(accept) - OUT_W'(rsp_eff);

    // A beat granted now is accepted no earlier than next cycle, so comparing
    // outstanding_next against the limit keeps the in-flight count bounded.
    assign slot_free = (state == S_RUN) && (!wr_valid_o || wr_ready_i)
                       && (outstanding_next < OUT_MAX);

    // Scan downward and keep the last hit, which is the first eligible from rr_ptr.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        scan_j    = 0;
        if (hold_i && lock_active) begin
            grant_hit = eligible[lock_idx];
            grant_idx = lock_idx;
        end else begin
            for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
                scan_j = int'(rr_ptr) + i;
                if (scan_j >= NUM_OUTPUTS) scan_j = scan_j - NUM_OUTPUTS;
                if (eligible[IDX_W'(scan_j)]) begin
                    grant_hit = 1'b1;
                    grant_idx = IDX_W'(scan_j);
                end
            end
        end
    end

    assign grant = grant_hit && slot_free;

    always_comb begin
        grant_data = '0;
        grant_addr = '0;
        ready_o    = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                grant_data = data_i[k*DATA_WIDTH +: DATA_WIDTH];
                grant_addr = cur_addr[k];
                ready_o[k] = grant;
            end
        end
    end

    assign busy_o  = (state == S_RUN) || (state == S_DRAIN);
    assign done_o  = (state == S_DONE);
    assign stall_o = (state == S_RUN) && any_eligible && (outstanding == OUT_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            wr_valid_o  <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            rr_ptr      <= '0;
            outstanding <= '0;
            lock_valid  <= 1'b0;
            lock_idx    <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                cur_addr[k] <= '0;
                rem[k]      <= '0;
            end
        end else begin
            outstanding <= outstanding_next;

            if (grant) begin
                wr_valid_o          <= 1'b1;
                wr_addr_o           <= grant_addr;
                wr_data_o           <= grant_data;
                cur_addr[grant_idx] <= cur_addr[grant_idx] + ADDR_STEP;
                rem[grant_idx]      <= rem[grant_idx] - SIZE_WIDTH'(1);
                rr_ptr              <= (int'(grant_idx) == NUM_OUTPUTS - 1)
                                       ? '0 : grant_idx + IDX_W'(1);
                if (hold_i && !lock_active) begin
                    lock_valid <= 1'b1;
                    lock_idx   <= grant_idx;
                end
            end else if (accept) begin
                wr_valid_o <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        for (int k = 0; k < NUM_OUTPUTS; k++) begin
                            cur_addr[k] <= addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                            rem[k]      <= size_i[k*SIZE_WIDTH +: SIZE_WIDTH];
                        end
                        rr_ptr     <= '0;
                        lock_valid <= 1'b0;
                        state      <= start_zero ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (all_zero) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!wr_valid_o && outstanding_next == '0) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cgra_output_arbiter.sv
// tb/tb_cgra_output_arbiter.sv - directed scoreboard bench for cgra_output_arbiter
module tb_cgra_output_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic           hold_i = 1'b0;
    logic [N*32-1:0] addr_i = '0;
    logic [N*16-1:0] size_i = '0;
    logic [N*32-1:0] data_i = '0;
    logic [N-1:0]   valid_i = '0;
    logic [N-1:0]   ready_o;
    logic           wr_valid_o;
    logic           wr_ready_i = 1'b0;
    logic [31:0]    wr_addr_o;
    logic [31:0]    wr_data_o;
    logic           wr_rsp_i = 1'b0;
    logic           busy_o, done_o, stall_o;

    always #5 clk = ~clk;

    cgra_output_arbiter dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hold_i(hold_i),
        .addr_i(addr_i), .size_i(size_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_rsp_i(wr_rsp_i),
        .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
    );

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } exp_t;

    exp_t       sb[$];
    int         rsp_due[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         writes = 0;
    int         last_rsp_cyc = -1;
    int         w0;
    int         beat [N];
    logic       rsp_en = 1'b0;
    logic [N-1:0] hs = '0;
    logic [N-1:0] ready_acc = '0;

    function automatic logic [31:0] mkdata(input int k, input int b);
        return 32'hD000_0000 | (32'(k) << 16) | 32'(b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        hs = ready_o;
        ready_acc = ready_acc | ready_o;
        chk("ready_onehot", 64'($countones(ready_o) <= 1), 64'd1);
        if (wr_valid_o && wr_ready_i) begin
            writes++;
            if (rsp_en) rsp_due.push_back(cyc + 2);
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 64'(wr_addr_o), 64'(e.addr));
                chk("wr_data", 64'(wr_data_o), 64'(e.data));
            end
        end
    endtask

    task automatic tick();
        #1;
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (hs[k]) begin
                beat[k]++;
                data_i[k*32 +: 32] = mkdata(k, beat[k]);
            end
        end
        wr_rsp_i = 1'b0;
        if (rsp_due.size() != 0 && rsp_due[0] <= cyc) begin
            void'(rsp_due.pop_front());
            wr_rsp_i = 1'b1;
            last_rsp_cyc = cyc;
        end
    endtask

    task automatic set_stream(input int k, input logic [31:0] a, input logic [15:0] s);
        addr_i[k*32 +: 32] = a;
        size_i[k*16 +: 16] = s;
    endtask

    task automatic expect_beat(input int k, input logic [31:0] a, input int b);
        exp_t e;
        e.addr = a;
        e.data = mkdata(k, b);
        sb.push_back(e);
    endtask

    task automatic start_session();
        for (int k = 0; k < N; k++) begin
            beat[k] = 0;
            data_i[k*32 +: 32] = mkdata(k, 0);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_o), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        valid_i = '1;
        for (int i = 0; i < 3; i++) tick();
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        chk("rst_wr_data", 64'(wr_data_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);

        // Round-robin, one beat per stream in turn
        hold_i = 1'b0; wr_ready_i = 1'b1; rsp_en = 1'b1;
        for (int k = 0; k < N; k++) set_stream(k, 32'((k + 1) * 4096), 16'd2);
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < N; k++) expect_beat(k, 32'((k + 1) * 4096 + 4 * b), b);
        w0 = writes;
        start_session();
        chk("t1_busy", 64'(busy_o), 64'd1);
        wait_done("t1_done", 100);
        chk("t1_done_latency", 64'(cyc - last_rsp_cyc), 64'd1);
        chk("t1_writes", 64'(writes - w0), 64'd8);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        chk("t1_busy_low", 64'(busy_o), 64'd0);

        // Hold mode drains each stream before moving on
        hold_i = 1'b1;
        for (int k = 0; k < N; k++)
            for (int b = 0; b < 2; b++) expect_beat(k, 32'((k + 1) * 4096 + 4 * b), b);
        w0 = writes;
        start_session();
        wait_done("t2_done", 100);
        chk("t2_done_latency", 64'(cyc - last_rsp_cyc), 64'd1);
        chk("t2_writes", 64'(writes - w0), 64'd8);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);
        hold_i = 1'b0;

        // Backpressure keeps the request stable; empty streams never get ready
        set_stream(0, 32'h5000, 16'd3);
        set_stream(1, 32'h5100, 16'd0);
        set_stream(2, 32'h5200, 16'd0);
        set_stream(3, 32'h6000, 16'd1);
        expect_beat(0, 32'h5000, 0);
        expect_beat(3, 32'h6000, 0);
        expect_beat(0, 32'h5004, 1);
        expect_beat(0, 32'h5008, 2);
        ready_acc = '0;
        w0 = writes;
        start_session();
        tick();
        tick();
        wr_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_valid", 64'(wr_valid_o), 64'd1);
            chk("t3_hold_addr", 64'(wr_addr_o), 64'h6000);
            chk("t3_hold_data", 64'(wr_data_o), 64'(mkdata(3, 0)));
            chk("t3_no_ready", 64'(ready_o), 64'd0);
            tick();
        end
        wr_ready_i = 1'b1;
        wait_done("t3_done", 100);
        chk("t3_writes", 64'(writes - w0), 64'd4);
        chk("t3_empty_streams_ready", 64'(ready_acc[2:1]), 64'd0);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Outstanding limit
        rsp_en = 1'b0;
        set_stream(0, 32'h8000, 16'd20);
        set_stream(3, 32'h0, 16'd0);
        for (int b = 0; b < 20; b++) expect_beat(0, 32'(32'h8000 + 4 * b), b);
        w0 = writes;
        start_session();
        for (int n = 0; n < 40 && !stall_o; n++) tick();
        chk("t4_stall", 64'(stall_o), 64'd1);
        chk("t4_writes_at_stall", 64'(writes - w0), 64'd8);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_no_ready", 64'(ready_o), 64'd0);
            chk("t4_stall_held", 64'(stall_o), 64'd1);
            tick();
        end
        rsp_due.push_back(cyc + 1);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_one_more", 64'(writes - w0), 64'd9);
        chk("t4_stall_again", 64'(stall_o), 64'd1);
        for (int i = 1; i <= 8; i++) rsp_due.push_back(cyc + i);
        rsp_en = 1'b1;
        wait_done("t4_done", 400);
        chk("t4_writes", 64'(writes - w0), 64'd20);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // All sizes zero
        for (int k = 0; k < N; k++) set_stream(k, 32'h0, 16'd0);
        w0 = writes;
        start_session();
        chk("t5_drain_busy", 64'(busy_o), 64'd1);
        chk("t5_drain_not_done", 64'(done_o), 64'd0);
        tick();
        chk("t5_done", 64'(done_o), 64'd1);
        chk("t5_not_busy", 64'(busy_o), 64'd0);
        chk("t5_no_writes", 64'(writes - w0), 64'd0);

        // start_i while busy is ignored
        valid_i = '0;
        set_stream(0, 32'h9000, 16'd3);
        for (int b = 0; b < 3; b++) expect_beat(0, 32'(32'h9000 + 4 * b), b);
        w0 = writes;
        start_session();
        for (int i = 0; i < 3; i++) tick();
        chk("t5b_busy", 64'(busy_o), 64'd1);
        chk("t5b_idle_writes", 64'(writes - w0), 64'd0);
        set_stream(0, 32'hA000, 16'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        valid_i = '1;
        wait_done("t5b_done", 100);
        chk("t5b_writes", 64'(writes - w0), 64'd3);
        chk("t5b_sb_empty", 64'(sb.size()), 64'd0);

        // Address wraps at the top of the space
        set_stream(0, 32'h0, 16'd0);
        set_stream(2, 32'hFFFF_FFFC, 16'd2);
        expect_beat(2, 32'hFFFF_FFFC, 0);
        expect_beat(2, 32'h0000_0000, 1);
        w0 = writes;
        start_session();
        wait_done("t5c_done", 100);
        chk("t5c_writes", 64'(writes - w0), 64'd2);
        chk("t5c_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-run, then stale responses must not upset the next session
        rsp_en = 1'b0;
        set_stream(2, 32'h0, 16'd0);
        set_stream(0, 32'h7000, 16'd10);
        for (int b = 0; b < 10; b++) expect_beat(0, 32'(32'h7000 + 4 * b), b);
        w0 = writes;
        start_session();
        for (int n = 0; n < 20 && (writes - w0) < 3; n++) tick();
        chk("t6_three_out", 64'(writes - w0), 64'd3);
        rst_i = 1'b1;
        tick();
        chk("t6_rst_ready", 64'(ready_o), 64'd0);
        chk("t6_rst_wr_valid", 64'(wr_valid_o), 64'd0);
        chk("t6_rst_wr_addr", 64'(wr_addr_o), 64'd0);
        chk("t6_rst_wr_data", 64'(wr_data_o), 64'd0);
        chk("t6_rst_busy", 64'(busy_o), 64'd0);
        chk("t6_rst_done", 64'(done_o), 64'd0);
        chk("t6_rst_stall", 64'(stall_o), 64'd0);
        rst_i = 1'b0;
        sb.delete();
        rsp_due.delete();
        rsp_due.push_back(cyc + 1);
        rsp_due.push_back(cyc + 2);
        for (int i = 0; i < 3; i++) tick();
        set_stream(0, 32'hB000, 16'd1);
        set_stream(1, 32'hC000, 16'd1);
        expect_beat(0, 32'hB000, 0);
        expect_beat(1, 32'hC000, 0);
        rsp_en = 1'b1;
        w0 = writes;
        start_session();
        wait_done("t6_done", 100);
        chk("t6_writes", 64'(writes - w0), 64'd2);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
